// File: rtl/taillight_pkg.sv
// Shared types and lamp pattern constants for the tail-light sequence observer.
// A lamp sample is packed as {La,Lb,Lc,Ra,Rb,Rc}.
package taillight_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_HAZARD = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1,
        ST_L2,
        ST_L3,
        ST_R1,
        ST_R2,
        ST_R3,
        ST_HAZ
    } dec_state_t;

    localparam logic [5:0] PAT_DARK = 6'b000_000;
    localparam logic [5:0] PAT_L1   = 6'b100_000;
    localparam logic [5:0] PAT_L2   = 6'b110_000;
    localparam logic [5:0] PAT_L3   = 6'b111_000;
    localparam logic [5:0] PAT_R1   = 6'b000_100;
    localparam logic [5:0] PAT_R2   = 6'b000_110;
    localparam logic [5:0] PAT_R3   = 6'b000_111;
    localparam logic [5:0] PAT_HAZ  = 6'b111_111;

endpackage

// File: rtl/taillight_idle_timer.sv
// Saturating run-length counter of consecutive enabled cycles.
// 'expired' is high on the enabled cycle that brings the count to IDLE_TIMEOUT,
// and on every enabled cycle after that while saturated, so the owner can
// register its timeout action on the same edge the count completes.
module taillight_idle_timer #(
    parameter int IDLE_TIMEOUT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(IDLE_TIMEOUT);
    localparam logic [W-1:0] LAST  = W'(IDLE_TIMEOUT - 1);

    logic [W-1:0] count_q, count_d;

    // Next count: clear wins, otherwise count up until saturated.
    always_comb begin
        // NOTE: default assignment first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = en && !clr && (count_q >= LAST);

endmodule

// File: rtl/taillight_decoder.sv
// Observer for the six-lamp turn-signal bus: tracks the legal left, right and
// hazard sequences, reports the last completed mode, counts completions and
// flags illegal samples. Optional build macro TAILLIGHT_DEC_STICKY_ERR_EN makes
// seq_err sticky until reset; otherwise it pulses once per illegal sample.
module taillight_decoder
    import taillight_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             La,
    input  logic             Lb,
    input  logic             Lc,
    input  logic             Ra,
    input  logic             Rb,
    input  logic             Rc,
    output logic [1:0]       mode,
    output logic             mode_valid,
    output logic             seq_err,
    output logic [CNT_W-1:0] seq_count
);

    logic [5:0]       sample;
    logic             dark;
    dec_state_t       state_q, state_d;
    mode_t            mode_q, mode_d, done_mode;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             complete;
    logic             illegal;
    logic             timer_expired;

    assign sample = {La, Lb, Lc, Ra, Rb, Rc};
    assign dark   = (sample == PAT_DARK);

    // A dark sample always leads to IDLE, so a run of dark samples is exactly
    // the time spent idle; any lit sample restarts the run.
    taillight_idle_timer #(
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!dark),
        .en      (dark),
        .expired (timer_expired)
    );

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_OFF;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // Next state plus completion / illegal-sample classification.
    always_comb begin
        state_d   = state_q;
        complete  = 1'b0;
        illegal   = 1'b0;
        done_mode = MODE_OFF;
        unique case (state_q)
            ST_IDLE: begin
                if (sample == PAT_L1) begin
                    state_d = ST_L1;
                end else if (sample == PAT_R1) begin
                    state_d = ST_R1;
                end else if (sample == PAT_HAZ) begin
                    state_d   = ST_HAZ;
                    complete  = 1'b1;
                    done_mode = MODE_HAZARD;
                end else if (!dark) begin
                    illegal = 1'b1;
                end
            end
            ST_L1: begin
                if (sample == PAT_L2) state_d = ST_L2;
                else if (dark)        state_d = ST_IDLE;
                else                  illegal = 1'b1;
            end
            ST_L2: begin
                if (sample == PAT_L3) begin
                    state_d   = ST_L3;
                    complete  = 1'b1;
                    done_mode = MODE_LEFT;
                end else if (dark) begin
                    state_d = ST_IDLE;
                end else begin
                    illegal = 1'b1;
                end
            end
            ST_R1: begin
                if (sample == PAT_R2) state_d = ST_R2;
                else if (dark)        state_d = ST_IDLE;
                else                  illegal = 1'b1;
            end
            ST_R2: begin
                if (sample == PAT_R3) begin
                    state_d   = ST_R3;
                    complete  = 1'b1;
                    done_mode = MODE_RIGHT;
                end else if (dark) begin
                    state_d = ST_IDLE;
                end else begin
                    illegal = 1'b1;
                end
            end
            ST_L3, ST_R3, ST_HAZ: begin
                if (dark) state_d = ST_IDLE;
                else      illegal = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // An illegal sample that is itself a start pattern begins a new sequence.
        if (illegal) begin
            if (sample == PAT_L1) begin
                state_d = ST_L1;
            end else if (sample == PAT_R1) begin
                state_d = ST_R1;
            end else if (sample == PAT_HAZ) begin
                state_d   = ST_HAZ;
                complete  = 1'b1;
                done_mode = MODE_HAZARD;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Next values of mode, validity, counter and error flag.
    always_comb begin
        mode_d  = mode_q;
        valid_d = valid_q;
        count_d = count_q;
        if (illegal) begin
            valid_d = 1'b0;
        end
        // A hazard restart after an illegal sample still completes a sequence.
        if (complete) begin
            mode_d  = done_mode;
            valid_d = 1'b1;
            count_d = count_q + 1'b1;
        end
        if (timer_expired) begin
            mode_d  = MODE_OFF;
            valid_d = 1'b0;
        end
`ifdef TAILLIGHT_DEC_STICKY_ERR_EN
        err_d = err_q | illegal;
`else
        err_d = illegal;
`endif
    end

    assign mode       = mode_q;
    assign mode_valid = valid_q;
    assign seq_err    = err_q;
    assign seq_count  = count_q;

endmodule

// File: tb/tb_taillight_decoder.sv
// Self-checking bench for taillight_decoder: directed scenarios plus random
// lamp streams, scored against a sequence-table reference model. The driver
// pushes one expected result per sample; a monitor pops and compares after
// each rising edge.
module tb_taillight_decoder;
    import taillight_pkg::*;

    localparam int IDLE_TIMEOUT = 4;
    localparam int CNT_W        = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             La = 1'b0, Lb = 1'b0, Lc = 1'b0;
    logic             Ra = 1'b0, Rb = 1'b0, Rc = 1'b0;
    logic [1:0]       mode;
    logic             mode_valid;
    logic             seq_err;
    logic [CNT_W-1:0] seq_count;

    always #5 clk = ~clk;

    taillight_decoder #(
        .IDLE_TIMEOUT(IDLE_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .La         (La),
        .Lb         (Lb),
        .Lc         (Lc),
        .Ra         (Ra),
        .Rb         (Rb),
        .Rc         (Rc),
        .mode       (mode),
        .mode_valid (mode_valid),
        .seq_err    (seq_err),
        .seq_count  (seq_count)
    );

    typedef struct {
        int mode;
        int valid;
        int err;
        int count;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: kind 0 = none, 1 = left, 2 = right, 3 = hazard.
    logic [5:0] seq_tab [0:3][0:2];
    int         seq_len [0:3] = '{0, 3, 3, 1};
    int         m_kind, m_step, m_dark, m_mode, m_count;
    bit         m_valid, m_sticky;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int start_kind(input logic [5:0] p);
        for (int k = 1; k <= 3; k++)
            if (p == seq_tab[k][0]) return k;
        return 0;
    endfunction

    task automatic model_reset();
        m_kind = 0; m_step = 0; m_dark = 0; m_mode = 0; m_count = 0;
        m_valid = 1'b0; m_sticky = 1'b0;
    endtask

    task automatic model_step(input logic [5:0] p, output exp_t e);
        bit err;
        bit progressed;
        int k;
        err = 1'b0;
        progressed = 1'b0;
        if (p == PAT_DARK) begin
            m_kind = 0;
            m_step = 0;
            if (m_dark < IDLE_TIMEOUT) m_dark++;
            if (m_dark >= IDLE_TIMEOUT) begin
                m_mode  = 0;
                m_valid = 1'b0;
            end
        end else begin
            m_dark = 0;
            if (m_kind != 0 && m_step < seq_len[m_kind] && p == seq_tab[m_kind][m_step]) begin
                m_step++;
                progressed = 1'b1;
            end else begin
                k = start_kind(p);
                err = (m_kind != 0) || (k == 0);
                m_kind = k;
                m_step = (k != 0) ? 1 : 0;
                progressed = (k != 0);
            end
            if (err) m_valid = 1'b0;
            if (progressed && m_step == seq_len[m_kind]) begin
                m_mode  = m_kind;
                m_valid = 1'b1;
                m_count = (m_count + 1) % (1 << CNT_W);
            end
        end
        m_sticky = m_sticky | err;
        e.mode  = m_mode;
        e.valid = int'(m_valid);
`ifdef TAILLIGHT_DEC_STICKY_ERR_EN
        e.err   = int'(m_sticky);
`else
        e.err   = int'(err);
`endif
        e.count = m_count;
    endtask

    task automatic send(input logic [5:0] p);
        exp_t e;
        @(negedge clk);
        {La, Lb, Lc, Ra, Rb, Rc} = p;
        model_step(p, e);
        sb_q.push_back(e);
    endtask

    task automatic send_darks(input int n);
        for (int i = 0; i < n; i++) send(PAT_DARK);
    endtask

    // Asserts reset mid-cycle, checks outputs clear before any edge, holds across an edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        {La, Lb, Lc, Ra, Rb, Rc} = PAT_DARK;
        #1;
        check("rst_mode",  8'(mode),       8'd0);
        check("rst_valid", 8'(mode_valid), 8'd0);
        check("rst_err",   8'(seq_err),    8'd0);
        check("rst_count", 8'(seq_count),  8'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: one expected entry per sampled edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("mode",       8'(mode),       8'(e.mode));
            check("mode_valid", 8'(mode_valid), 8'(e.valid));
            check("seq_err",    8'(seq_err),    8'(e.err));
            check("seq_count",  8'(seq_count),  8'(e.count));
        end
    end

    initial begin
        int r, k, stop, nd;
        logic [5:0] p;

        seq_tab[0] = '{PAT_DARK, PAT_DARK, PAT_DARK};
        seq_tab[1] = '{PAT_L1, PAT_L2, PAT_L3};
        seq_tab[2] = '{PAT_R1, PAT_R2, PAT_R3};
        seq_tab[3] = '{PAT_HAZ, PAT_DARK, PAT_DARK};
        model_reset();

        do_reset();

        // Left sequence then timeout.
        send(PAT_L1); send(PAT_L2); send(PAT_L3);
        send_darks(4);

        // Hazard flashes.
        for (int i = 0; i < 3; i++) begin
            send(PAT_HAZ);
            send(PAT_DARK);
        end

        // Skipped step is illegal.
        send(PAT_L1); send(PAT_L3); send(PAT_DARK);

        // Completed left, then an aborted right keeps mode and count.
        send(PAT_L1); send(PAT_L2); send(PAT_L3); send(PAT_DARK);
        send(PAT_R1); send(PAT_R2); send(PAT_DARK);

        // Held mid-sequence pattern is illegal.
        send(PAT_R1); send(PAT_R1); send(PAT_R2); send(PAT_R3); send_darks(2);

        // Counter wrap with back-to-back left sequences.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(PAT_L1); send(PAT_L2); send(PAT_L3); send(PAT_DARK);
        end
        send_darks(5);

        // Random streams mixing legal, aborted and arbitrary patterns.
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                k = $urandom_range(1, 3);
                stop = ($urandom_range(0, 4) == 0) ? $urandom_range(1, seq_len[k]) : seq_len[k];
                for (int s = 0; s < stop; s++) send(seq_tab[k][s]);
                nd = $urandom_range(0, 5);
                send_darks(nd);
            end else if (r < 8) begin
                p = seq_tab[$urandom_range(1, 3)][$urandom_range(0, 2)];
                send(p);
            end else begin
                p = 6'($urandom);
                send(p);
            end
        end
        send_darks(2);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drain", 8'(sb_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
